// File: rtl/btn_pkg.sv
// Shared types and 27 MHz timing defaults for the push-button event generator.
// Latency: none (types and constants only).
// Backpressure: none.
package btn_pkg;

   // Button FSM: released, held below the long-press threshold, held past it
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HELD      = 2'd1,
      LONG_HELD = 2'd2
   } btn_state_t;

   // Cycle counts for a 27 MHz board clock
   localparam int unsigned DEBOUNCE_10MS = 270_000;
   localparam int unsigned LONG_500MS    = 13_500_000;
   localparam int unsigned REPEAT_100MS  = 2_700_000;

endpackage

// File: rtl/btn_event_gen_if.sv
// Bundle between one board button pin, its event generator and the consumer logic.
// Latency: none (wires only).
// Backpressure: none; event strobes last one cycle and must be sampled every cycle.
interface btn_event_gen_if;

   logic btn_n;          // raw pin, active low, asynchronous
   logic pressed;        // debounced level
   logic press_pulse;    // accepted press (and auto-repeat)
   logic release_pulse;  // accepted release
   logic long_pulse;     // hold reached the long-press threshold

   // Producer side: the event generator
   modport master (
      input  btn_n,
      output pressed,
      output press_pulse,
      output release_pulse,
      output long_pulse
   );

   // Board/consumer side: owns the pin, receives the events
   modport slave (
      output btn_n,
      input  pressed,
      input  press_pulse,
      input  release_pulse,
      input  long_pulse
   );

endinterface

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one asynchronous pin, with configurable reset value.
// Latency: 2 cycles from pin change to q.
// Backpressure: none.
module btn_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the pin through two flops; reset loads the idle level
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/btn_event_gen.sv
// Debounces one active-low button into a level plus press/release/long-press strobes; BTN_AUTOREPEAT_EN adds repeat presses.
// Latency: clean pin edge to press_pulse/release_pulse is 2+DEBOUNCE_CYCLES cycles; long_pulse LONG_CYCLES after press_pulse.
// Backpressure: none; strobes are one cycle wide and at most one is high per cycle.
module btn_event_gen
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
   parameter int unsigned LONG_CYCLES     = LONG_500MS,
   parameter int unsigned REPEAT_CYCLES   = REPEAT_100MS
) (
   input  logic           clk,
   input  logic           rst,
   btn_event_gen_if.master bus
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

   // All counts must be at least one cycle for the compare-at-last scheme to work
   if (DEBOUNCE_CYCLES == 0 || LONG_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_bad_params
      $error("btn_event_gen: cycle counts must be non-zero");
   end

   // ------------------------------------------------------------------
   // Synchronizer and debounce
   // ------------------------------------------------------------------
   logic          s_n;       // synchronized pin, active low
   logic          acc_n;     // accepted (debounced) level, active low
   logic [DW-1:0] deb_cnt;
   logic          differ;
   logic          accept;
   logic          press_evt;
   logic          rel_evt;

   btn_sync #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.btn_n),
      .q   (s_n)
   );

   assign differ    = (s_n != acc_n);
   assign accept    = differ && (deb_cnt == DEB_LAST);
   assign press_evt = accept && !s_n;
   assign rel_evt   = accept && s_n;

   // Count consecutive differing cycles; any matching cycle restarts the count
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_n   <= 1'b1;
         deb_cnt <= '0;
      end else if (!differ) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
         acc_n   <= s_n;
         deb_cnt <= '0;
      end else begin
         deb_cnt <= deb_cnt + DW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Hold FSM
   // ------------------------------------------------------------------
   btn_state_t    state;
   btn_state_t    state_nxt;
   logic [HW-1:0] hold_cnt;
   logic [HW-1:0] hold_nxt;
   logic          rep_wrap;   // a repeat press is due this cycle
   logic          press_nxt;
   logic          rel_nxt;
   logic          long_nxt;
   logic          press_q;
   logic          rel_q;
   logic          long_q;

`ifdef BTN_AUTOREPEAT_EN
   localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep_cnt;

   // Release beats a repeat landing in the same cycle
   assign rep_wrap = (state == LONG_HELD) && !rel_evt && (rep_cnt == REP_LAST);

   // Count LONG_HELD cycles; restart on each repeat and outside LONG_HELD
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt <= '0;
      end else if (state != LONG_HELD || rep_wrap) begin
         rep_cnt <= '0;
      end else begin
         rep_cnt <= rep_cnt + RW'(1);
      end
   end
`else
   assign rep_wrap = 1'b0;
`endif

   // State, hold counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
         press_q  <= 1'b0;
         rel_q    <= 1'b0;
         long_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         press_q  <= press_nxt;
         rel_q    <= rel_nxt;
         long_q   <= long_nxt;
      end
   end

   // Transitions; release is checked before the long threshold so it wins ties
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      case (state)
         IDLE: begin
            hold_nxt = '0;
            if (press_evt) begin
               state_nxt = HELD;
            end
         end
         HELD: begin
            if (rel_evt) begin
               state_nxt = IDLE;
               hold_nxt  = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nxt = LONG_HELD;
               hold_nxt  = HOLD_MAX;
            end else begin
               hold_nxt = hold_cnt + HW'(1);
            end
         end
         LONG_HELD: begin
            // hold counter stays saturated at HOLD_MAX
            if (rel_evt) begin
               state_nxt = IDLE;
               hold_nxt  = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            hold_nxt  = '0;
         end
      endcase
   end

   // Strobes for the cycle after each transition; mutually exclusive by state
   always_comb begin
      press_nxt = 1'b0;
      rel_nxt   = 1'b0;
      long_nxt  = 1'b0;
      case (state)
         IDLE: begin
            press_nxt = press_evt;
         end
         HELD: begin
            rel_nxt  = rel_evt;
            long_nxt = !rel_evt && (hold_cnt == HOLD_LAST);
         end
         LONG_HELD: begin
            rel_nxt   = rel_evt;
            press_nxt = rep_wrap;
         end
         default: begin
            press_nxt = 1'b0;
         end
      endcase
   end

   assign bus.pressed       = (state != IDLE);
   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = rel_q;
   assign bus.long_pulse    = long_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Scoreboard bench for btn_event_gen with DEBOUNCE=4, LONG=20, REPEAT=8.
// Stimulus pushes expected events/levels; the monitor compares on every falling edge.
// Runs to completion on its own and prints a single summary line.
module tb_btn_event_gen;

   localparam int DEB  = 4;
   localparam int LONG = 20;
   localparam int REP  = 8;
   localparam int NV   = 7;

   typedef enum logic [1:0] {EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_t;

   typedef struct {
      ev_kind_t kind;
      int       cyc;
   } ev_t;

   typedef struct {
      string      name;
      int         cyc;
      logic [3:0] val;   // {pressed, press, release, long}
      logic [3:0] mask;
   } lvl_t;

   // hold/gap in cycles; p/l/r are event offsets from the falling drive, -1 = none
   typedef struct packed {
      int hold;
      int gap;
      int p;
      int l;
      int r;
      bit pr;   // pressed expected at the cycle btn_n is released
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_q = 1'b1;
   int   cyc = 0;
   bit   done = 1'b0;

   btn_event_gen_if bus ();

   btn_event_gen #(
      .DEBOUNCE_CYCLES (DEB),
      .LONG_CYCLES     (LONG),
      .REPEAT_CYCLES   (REP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   ev_t  exp_q[$];
   lvl_t lvl_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // hand-computed: press 2+DEB after fall, long LONG after press, release 2+DEB after rise
   vec_t vecs [NV] = '{
      '{30, 20,  6, 26, 36, 1'b1},   // press, long, release
      '{ 3, 10, -1, -1, -1, 1'b0},   // 3-cycle glitch: rejected
      '{ 4, 12,  6, -1, 10, 1'b0},   // shortest accepted press
      '{16, 12,  6, -1, 22, 1'b1},   // short hold, no long
      '{20, 12,  6, -1, 26, 1'b1},   // release accepted on the long threshold cycle
      '{21, 12,  6, 26, 27, 1'b1},   // release one cycle after threshold
      '{86, 20,  6, 26, 92, 1'b1}    // 60+ cycles past long
   };

   function automatic string kname(input ev_kind_t k);
      case (k)
         EV_PRESS:   return "press";
         EV_RELEASE: return "release";
         default:    return "long";
      endcase
   endfunction

   task automatic push_ev(input ev_kind_t k, input int c);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic push_lvl(input string n, input int c, input logic [3:0] v, input logic [3:0] m);
      lvl_t l;
      l.name = n;
      l.cyc  = c;
      l.val  = v;
      l.mask = m;
      lvl_q.push_back(l);
   endtask

   // Called on a falling edge: drive a press of v.hold cycles followed by v.gap released cycles
   task automatic run_vec(input vec_t v);
      int t;
      t = cyc;
      if (v.p >= 0) push_ev(EV_PRESS, t + v.p);
      if (v.l >= 0) begin
         push_ev(EV_LONG, t + v.l);
`ifdef BTN_AUTOREPEAT_EN
         for (int k = t + v.l + REP; k < t + v.r; k += REP) push_ev(EV_PRESS, k);
`endif
      end
      if (v.r >= 0) push_ev(EV_RELEASE, t + v.r);
      push_lvl("pressed_at_release", t + v.hold, {v.pr, 3'b000}, 4'b1000);
      bus.btn_n = 1'b0;
      repeat (v.hold) @(negedge clk);
      bus.btn_n = 1'b1;
      repeat (v.gap) @(negedge clk);
   endtask

   // Monitor / scoreboard
   int         npulse;
   ev_kind_t   got;
   ev_t        ev;
   lvl_t       lv;
   logic       prev_pressed = 1'b0;
   logic [3:0] outs;

   always @(negedge clk) begin
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
         n_tests++;
         n_fail++;
         $display("FAIL missed_%s: no pulse seen at cycle %0d, required one there",
                  kname(exp_q[0].kind), exp_q[0].cyc);
         void'(exp_q.pop_front());
      end

      npulse = int'(bus.press_pulse) + int'(bus.release_pulse) + int'(bus.long_pulse);
      if (npulse != 0) begin
         n_tests++;
         if (npulse > 1) begin
            n_fail++;
            $display("FAIL one_hot: press=%0b release=%0b long=%0b at cycle %0d, required at most one",
                     bus.press_pulse, bus.release_pulse, bus.long_pulse, cyc);
         end
         got = bus.press_pulse ? EV_PRESS : (bus.release_pulse ? EV_RELEASE : EV_LONG);
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: pulse at cycle %0d, required none", kname(got), cyc);
         end else begin
            ev = exp_q.pop_front();
            if (ev.kind != got || ev.cyc != cyc) begin
               n_fail++;
               $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                        kname(got), cyc, kname(ev.kind), ev.cyc);
            end
         end
      end

      if (bus.pressed != prev_pressed && !rst_q) begin
         n_tests++;
         if (bus.pressed ? !bus.press_pulse : !bus.release_pulse) begin
            n_fail++;
            $display("FAIL pressed_edge: pressed=%0b press=%0b release=%0b at cycle %0d, required matching pulse",
                     bus.pressed, bus.press_pulse, bus.release_pulse, cyc);
         end
      end
      prev_pressed = bus.pressed;

      outs = {bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse};
      if (lvl_q.size() != 0 && lvl_q[0].cyc <= cyc) begin
         lv = lvl_q.pop_front();
         n_tests++;
         if (lv.cyc != cyc || ((outs ^ lv.val) & lv.mask) != 4'b0000) begin
            n_fail++;
            $display("FAIL %s: outputs %b at cycle %0d, required %b (mask %b) at cycle %0d",
                     lv.name, outs, cyc, lv.val, lv.mask, lv.cyc);
         end
      end

      if (done) begin
         n_tests++;
         if (exp_q.size() != 0 || lvl_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d events and %0d level checks pending, required 0 and 0",
                     exp_q.size(), lvl_q.size());
         end
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $finish;
      end
   end

   // Stimulus
   initial begin
      int t;
      int d;
      bus.btn_n = 1'b1;
      rst       = 1'b1;
      repeat (2) @(negedge clk);
      push_lvl("reset_state", cyc + 1, 4'b0000, 4'b1111);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      run_vec(vecs[0]);
      run_vec(vecs[1]);

      // bounce 0/1/0/1, then a clean press measured from the last falling edge
      t = cyc + 4;
      push_ev(EV_PRESS, t + 6);
      push_ev(EV_RELEASE, t + 22);
      bus.btn_n = 1'b0; @(negedge clk);
      bus.btn_n = 1'b1; @(negedge clk);
      bus.btn_n = 1'b0; @(negedge clk);
      bus.btn_n = 1'b1; @(negedge clk);
      bus.btn_n = 1'b0; repeat (16) @(negedge clk);
      bus.btn_n = 1'b1; repeat (12) @(negedge clk);

      for (int i = 2; i < NV; i++) run_vec(vecs[i]);

      // reset while held: outputs clear, no release, then a fresh debounced press
      t = cyc;
      push_ev(EV_PRESS, t + 6);
      push_lvl("held_before_rst", t + 9, 4'b1000, 4'b1111);
      bus.btn_n = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      push_lvl("rst_mid_hold", cyc + 1, 4'b0000, 4'b1111);
      @(negedge clk);
      rst = 1'b0;
      d = cyc;
      push_ev(EV_PRESS, d + 6);
      push_ev(EV_RELEASE, d + 16);
      repeat (10) @(negedge clk);
      bus.btn_n = 1'b1;
      repeat (12) @(negedge clk);

      repeat (5) @(negedge clk);
      done = 1'b1;
   end

   initial begin
      #100000;
      $display("FAIL timeout: time %0t reached without finishing, required completion", $time);
      $fatal(1, "timeout");
   end

endmodule
